bin_to_bcd_seq: RTL and testbench



---
 rtl/bin_to_bcd_seq_if.sv | 30 +++
 rtl/bin_to_bcd_seq.sv | 111 +++++++++++
 tb/tb_bin_to_bcd_seq.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/bin_to_bcd_seq_if.sv
// rtl/bin_to_bcd_seq_if.sv - start/busy/done handshake and result bundle for the BCD converter
interface bin_to_bcd_seq_if #(
    parameter int BIN_WIDTH = 27,
    parameter int DIGITS    = 8
);
    logic                  start;
    logic [BIN_WIDTH-1:0]  bin_in;
    logic                  busy;
    logic                  done;
    logic [4*DIGITS-1:0]   bcd_out;
    logic                  overflow;

    modport master (
        output start,
        output bin_in,
        input  busy,
        input  done,
        input  bcd_out,
        input  overflow
    );

    modport slave (
        input  start,
        input  bin_in,
        output busy,
        output done,
        output bcd_out,
        output overflow
    );
endinterface

// File: rtl/bin_to_bcd_seq.sv
// rtl/bin_to_bcd_seq.sv - sequential double-dabble binary to packed BCD converter
module bin_to_bcd_seq #(
    parameter int BIN_WIDTH = 27,
    parameter int DIGITS    = 8
) (
    input  logic              clock,
    input  logic              reset,
    bin_to_bcd_seq_if.slave   cif
);
    localparam int BCD_W = 4 * DIGITS;
    localparam int SR_W  = BCD_W + BIN_WIDTH;
    localparam int CNT_W = $clog2(BIN_WIDTH + 1);

    function automatic logic [63:0] pow10(input int n);
        logic [63:0] r;
        r = 64'd1;
        for (int i = 0; i < n; i++) begin
            r = r * 64'd10;
        end
        return r;
    endfunction

    localparam logic [63:0] MAX_VAL = pow10(DIGITS) - 64'd1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [SR_W-1:0]    shift_q, shift_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ovf_pend_q, ovf_pend_d;
    logic [BCD_W-1:0]   bcd_q, bcd_d;
    logic               overflow_q, overflow_d;
    logic               done_q, done_d;
    logic [SR_W-1:0]    adj;
    logic [63:0]        bin_ext;

    assign bin_ext = 64'(cif.bin_in);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            cnt_q      <= '0;
            ovf_pend_q <= 1'b0;
            bcd_q      <= '0;
            overflow_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            cnt_q      <= cnt_d;
            ovf_pend_q <= ovf_pend_d;
            bcd_q      <= bcd_d;
            overflow_q <= overflow_d;
            done_q     <= done_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        cnt_d      = cnt_q;
        ovf_pend_d = ovf_pend_q;
        bcd_d      = bcd_q;
        overflow_d = overflow_q;
        done_d     = 1'b0;
        adj        = shift_q;

        case (state_q)
            IDLE: begin
                if (cif.start) begin
                    shift_d    = {{BCD_W{1'b0}}, cif.bin_in};
                    cnt_d      = CNT_W'(BIN_WIDTH);
                    ovf_pend_d = (bin_ext > MAX_VAL);
                    state_d    = CONV;
                end
            end
            CONV: begin
                // Per-digit +3 correction is independent: no carry crosses a nibble.
                for (int k = 0; k < DIGITS; k++) begin
                    if (adj[BIN_WIDTH + 4*k +: 4] >= 4'd5) begin
                        adj[BIN_WIDTH + 4*k +: 4] = adj[BIN_WIDTH + 4*k +: 4] + 4'd3;
                    end
                end
                shift_d = {adj[SR_W-2:0], 1'b0};
                cnt_d   = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                bcd_d      = ovf_pend_q ? {BCD_W{1'b1}} : shift_q[SR_W-1 -: BCD_W];
                overflow_d = ovf_pend_q;
                done_d     = 1'b1;
                state_d    = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign cif.busy     = (state_q != IDLE);
    assign cif.done     = done_q;
    assign cif.bcd_out  = bcd_q;
    assign cif.overflow = overflow_q;
endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// tb/tb_bin_to_bcd_seq.sv - directed self-checking bench for bin_to_bcd_seq
module tb_bin_to_bcd_seq;
    logic clock = 1'b0;
    logic reset;

    always #5 clock = ~clock;

    bin_to_bcd_seq_if #(.BIN_WIDTH(27), .DIGITS(8)) cif ();

    bin_to_bcd_seq #(.BIN_WIDTH(27), .DIGITS(8)) dut (
        .clock (clock),
        .reset (reset),
        .cif   (cif)
    );

    int checks = 0;
    int passed = 0;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic run_conv(input logic [26:0] v, output logic [31:0] bcd, output logic ovf,
                            output int lat, output int busy_cnt, output logic stable_ok);
        logic [31:0] prev;
        prev      = cif.bcd_out;
        cif.start = 1'b1;
        cif.bin_in = v;
        tick();
        cif.start = 1'b0;
        lat       = 0;
        busy_cnt  = 0;
        stable_ok = 1'b1;
        while (cif.done !== 1'b1 && lat < 40) begin
            if (cif.busy === 1'b1) busy_cnt++;
            if (cif.bcd_out !== prev) stable_ok = 1'b0;
            tick();
            lat++;
        end
        bcd = cif.bcd_out;
        ovf = cif.overflow;
    endtask

    task automatic test_reset();
        reset      = 1'b1;
        cif.start  = 1'b0;
        cif.bin_in = '0;
        #12;
        checks++; if (cif.busy !== 1'b0) $display("FAIL reset_busy got %b want 0", cif.busy); else passed++;
        checks++; if (cif.done !== 1'b0) $display("FAIL reset_done got %b want 0", cif.done); else passed++;
        checks++; if (cif.bcd_out !== 32'h0) $display("FAIL reset_bcd got %h want 00000000", cif.bcd_out); else passed++;
        checks++; if (cif.overflow !== 1'b0) $display("FAIL reset_ovf got %b want 0", cif.overflow); else passed++;
        reset = 1'b0;
        tick();
    endtask

    task automatic test_zero();
        logic [31:0] bcd;
        logic ovf, st;
        int lat, bc;
        run_conv(27'd0, bcd, ovf, lat, bc, st);
        checks++; if (lat !== 28) $display("FAIL zero_latency got %0d want 28", lat); else passed++;
        checks++; if (bc !== 28) $display("FAIL zero_busy_cycles got %0d want 28", bc); else passed++;
        checks++; if (bcd !== 32'h0) $display("FAIL zero_bcd got %h want 00000000", bcd); else passed++;
        checks++; if (ovf !== 1'b0) $display("FAIL zero_ovf got %b want 0", ovf); else passed++;
        checks++; if (cif.busy !== 1'b0) $display("FAIL zero_busy_at_done got %b want 0", cif.busy); else passed++;
        tick();
    endtask

    task automatic test_values();
        logic [26:0] vin  [5] = '{27'h0BC614E, 27'd99999999, 27'd100000000, 27'h7FFFFFF, 27'd9};
        logic [31:0] vexp [5] = '{32'h12345678, 32'h99999999, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000009};
        logic        oexp [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        logic [31:0] bcd;
        logic ovf, st;
        int lat, bc;
        for (int i = 0; i < 5; i++) begin
            run_conv(vin[i], bcd, ovf, lat, bc, st);
            checks++; if (bcd !== vexp[i]) $display("FAIL value_bcd[%0d] got %h want %h", i, bcd, vexp[i]); else passed++;
            checks++; if (ovf !== oexp[i]) $display("FAIL value_ovf[%0d] got %b want %b", i, ovf, oexp[i]); else passed++;
            checks++; if (st !== 1'b1) $display("FAIL value_stable[%0d] got %b want 1", i, st); else passed++;
            tick();
            checks++; if (cif.done !== 1'b0) $display("FAIL value_done_width[%0d] got %b want 0", i, cif.done); else passed++;
        end
    endtask

    task automatic test_ignore_start();
        int lat;
        cif.start  = 1'b1;
        cif.bin_in = 27'd1234;
        tick();
        lat = 0;
        while (cif.done !== 1'b1 && lat < 40) begin
            cif.bin_in = (lat % 2 == 0) ? 27'd5555 : 27'd7777;
            tick();
            lat++;
        end
        cif.start = 1'b0;
        checks++; if (lat !== 28) $display("FAIL ignore_latency got %0d want 28", lat); else passed++;
        checks++; if (cif.bcd_out !== 32'h00001234) $display("FAIL ignore_bcd got %h want 00001234", cif.bcd_out); else passed++;
        tick();
        checks++; if (cif.busy !== 1'b0) $display("FAIL ignore_idle_after got %b want 0", cif.busy); else passed++;
    endtask

    task automatic test_back_to_back();
        int t;
        int times [$];
        cif.start  = 1'b1;
        cif.bin_in = 27'd42;
        tick();
        t = 0;
        while (times.size() < 3 && t < 100) begin
            tick();
            t++;
            if (cif.done === 1'b1) begin
                times.push_back(t);
                checks++; if (cif.bcd_out !== 32'h00000042) $display("FAIL b2b_bcd got %h want 00000042", cif.bcd_out); else passed++;
            end
        end
        cif.start = 1'b0;
        checks++; if (times.size() !== 3) $display("FAIL b2b_pulses got %0d want 3", times.size()); else passed++;
        if (times.size() == 3) begin
            checks++; if (times[0] !== 28) $display("FAIL b2b_first got %0d want 28", times[0]); else passed++;
            checks++; if (times[1] - times[0] !== 29) $display("FAIL b2b_gap1 got %0d want 29", times[1] - times[0]); else passed++;
            checks++; if (times[2] - times[1] !== 29) $display("FAIL b2b_gap2 got %0d want 29", times[2] - times[1]); else passed++;
        end
        tick();
        checks++; if (cif.busy !== 1'b0) $display("FAIL b2b_idle got %b want 0", cif.busy); else passed++;
    endtask

    task automatic test_reset_mid();
        logic [31:0] bcd;
        logic ovf, st;
        int lat, bc, dcnt;
        cif.start  = 1'b1;
        cif.bin_in = 27'd55555555;
        tick();
        cif.start = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        #2;
        reset = 1'b1;
        #1;
        checks++; if (cif.busy !== 1'b0) $display("FAIL rmid_busy got %b want 0", cif.busy); else passed++;
        checks++; if (cif.done !== 1'b0) $display("FAIL rmid_done got %b want 0", cif.done); else passed++;
        checks++; if (cif.bcd_out !== 32'h0) $display("FAIL rmid_bcd got %h want 00000000", cif.bcd_out); else passed++;
        checks++; if (cif.overflow !== 1'b0) $display("FAIL rmid_ovf got %b want 0", cif.overflow); else passed++;
        tick();
        tick();
        reset = 1'b0;
        dcnt = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (cif.done === 1'b1 || cif.busy === 1'b1) dcnt++;
        end
        checks++; if (dcnt !== 0) $display("FAIL rmid_no_activity got %0d want 0", dcnt); else passed++;
        run_conv(27'd55555555, bcd, ovf, lat, bc, st);
        checks++; if (lat !== 28) $display("FAIL rmid_latency got %0d want 28", lat); else passed++;
        checks++; if (bcd !== 32'h55555555) $display("FAIL rmid_bcd_after got %h want 55555555", bcd); else passed++;
        checks++; if (ovf !== 1'b0) $display("FAIL rmid_ovf_after got %b want 0", ovf); else passed++;
        tick();
    endtask

    initial begin
        test_reset();
        test_zero();
        test_values();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
